// File: rtl/automata_report_collector_if.sv
// Report-event output stream bus for automata_report_collector.
//   out_valid : head event available (driven by the collector)
//   out_ready : downstream reader accepts the head event
//   out_data  : {timestamp, report vector}, timestamp in the MSBs
// The master modport belongs to the collector and the slave modport to the reader.
interface automata_report_collector_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/automata_report_collector.sv
// automata_report_collector
// Timestamps the report wires of one automata stage and buffers every
// nonzero report vector seen while run=1 in a small FIFO for a downstream
// reader. Events that arrive while the FIFO is full are dropped and counted.
// Ports:
//   clk          : single clock, rising edge
//   reset        : synchronous active-high reset
//   run          : symbol-valid qualifier; advances the timestamp
//   reports      : report wires from the stage, bit 0 first
//   out          : event stream (out_valid / out_ready / out_data)
//   fifo_count   : number of buffered events
//   overflow     : sticky, set when an event has been dropped
//   drop_count   : saturating count of dropped events
//   clear_status : clears overflow and drop_count
module automata_report_collector #(
  parameter int NUM_REPORTS = 40,
  parameter int TS_WIDTH    = 24,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  input  logic [NUM_REPORTS-1:0]          reports,
  automata_report_collector_if.master     out,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic [15:0]                     drop_count,
  input  logic                            clear_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = TS_WIDTH + NUM_REPORTS;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] ts_q,       ts_d;
  logic [AW-1:0]       wrPtr_q,    wrPtr_d;
  logic [AW-1:0]       rdPtr_q,    rdPtr_d;
  logic [AW:0]         count_q,    count_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drops_q,    drops_d;

  logic pushReq;
  logic popReq;
  logic empty;
  logic full;
  logic accept;
  logic dropEvt;

  // Handshake decode. A full FIFO can still take a new event when the head
  // leaves on the same edge, so only push-while-full-without-pop drops.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DEPTH_C);
    pushReq = run && (reports != '0);
    popReq  = !empty && out.out_ready;
    accept  = pushReq && (!full || popReq);
    dropEvt = pushReq && full && !popReq;
  end

  // Next-state for timestamp, pointers, occupancy and status. Pointers wrap
  // for free because the depth is a power of two. A clear on the same edge
  // as a drop wins, so the drop is not recorded.
  always_comb begin
    ts_d       = ts_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drops_d    = drops_q;

    if (run) begin
      ts_d = ts_q + TS_WIDTH'(1);
    end
    if (accept) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (popReq) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    if (accept && !popReq) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!accept && popReq) begin
      count_d = count_q - (AW + 1)'(1);
    end

    if (clear_status) begin
      overflow_d = 1'b0;
      drops_d    = '0;
    end else if (dropEvt) begin
      overflow_d = 1'b1;
      if (drops_q != 16'hFFFF) begin
        drops_d = drops_q + 16'd1;
      end
    end
  end

  // Control state registers; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drops_q    <= '0;
    end else begin
      ts_q       <= ts_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drops_q    <= drops_d;
    end
  end

  // Event storage. The captured timestamp is the value before this edge's
  // increment. Contents need no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem_q[wrPtr_q] <= {ts_q, reports};
    end
  end

  // The head is masked to zero when nothing is buffered.
  assign out.out_valid = !empty;
  assign out.out_data  = empty ? '0 : mem_q[rdPtr_q];
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;
  assign drop_count    = drops_q;

endmodule

// File: tb/tb_automata_report_collector.sv
// Self-checking bench for automata_report_collector. A queue-based reference
// model tracks the buffered events, timestamp and drop status; directed
// scenarios are followed by a randomized phase. A second, narrow-timestamp
// instance exercises the timestamp wrap within a short run.
module tb_automata_report_collector;

  localparam int NR  = 40;
  localparam int TSW = 24;
  localparam int DEP = 8;
  localparam int DW  = TSW + NR;
  localparam int SMALL_TSW = 8;
  localparam int SMALL_DW  = SMALL_TSW + NR;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [NR-1:0] reports;
  logic          clear;
  logic [3:0]    fifoCount;
  logic          overflow;
  logic [15:0]   dropCount;

  logic          smallRun;
  logic [NR-1:0] smallReports;
  logic [2:0]    smallCount;
  logic          smallOverflow;
  logic [15:0]   smallDrops;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model state
  logic [DW-1:0]  modelQ[$];
  logic [TSW-1:0] modelTs;
  logic           modelOvf;
  int             modelDrops;

  automata_report_collector_if #(.DATA_WIDTH(DW)) bus ();
  automata_report_collector_if #(.DATA_WIDTH(SMALL_DW)) smallBus ();

  automata_report_collector #(
    .NUM_REPORTS(NR), .TS_WIDTH(TSW), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .reports(reports), .out(bus.master),
    .fifo_count(fifoCount), .overflow(overflow), .drop_count(dropCount),
    .clear_status(clear)
  );

  automata_report_collector #(
    .NUM_REPORTS(NR), .TS_WIDTH(SMALL_TSW), .FIFO_DEPTH(4)
  ) dutSmall (
    .clk(clk), .reset(reset), .run(smallRun), .reports(smallReports),
    .out(smallBus.master), .fifo_count(smallCount), .overflow(smallOverflow),
    .drop_count(smallDrops), .clear_status(1'b0)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Model one clock edge from the rules: reset clears everything; otherwise
  // the head leaves if the reader is ready, a nonzero report under run is
  // queued unless the queue was full and nothing left, clear beats a drop.
  task automatic modelStep(input bit r, input logic [NR-1:0] rep, input bit rdy,
                           input bit clr, input bit rst);
    bit wasFull, popped, pushing, dropped;
    if (rst) begin
      modelQ.delete();
      modelTs    = '0;
      modelOvf   = 1'b0;
      modelDrops = 0;
      return;
    end
    wasFull = (modelQ.size() == DEP);
    popped  = (modelQ.size() > 0) && rdy;
    pushing = r && (rep != '0);
    dropped = pushing && wasFull && !popped;
    if (popped) void'(modelQ.pop_front());
    if (pushing && !dropped) modelQ.push_back({modelTs, rep});
    if (clr) begin
      modelOvf   = 1'b0;
      modelDrops = 0;
    end else if (dropped) begin
      modelOvf = 1'b1;
      if (modelDrops < 65535) modelDrops++;
    end
    if (r) modelTs = modelTs + 1'b1;
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare all
  // main-instance outputs against the model.
  task automatic applyStimulus(input bit r, input logic [NR-1:0] rep, input bit rdy,
                               input bit clr, input bit rst);
    logic [DW-1:0] expData;
    run = r; reports = rep; bus.out_ready = rdy; clear = clr; reset = rst;
    @(posedge clk);
    modelStep(r, rep, rdy, clr, rst);
    #1;
    expData = (modelQ.size() > 0) ? modelQ[0] : '0;
    checkOutput("out_valid", 64'(bus.out_valid), 64'(modelQ.size() > 0));
    checkOutput("out_data", 64'(bus.out_data), 64'(expData));
    checkOutput("fifo_count", 64'(fifoCount), 64'(modelQ.size()));
    checkOutput("overflow", 64'(overflow), 64'(modelOvf));
    checkOutput("drop_count", 64'(dropCount), 64'(modelDrops));
  endtask

  function automatic logic [NR-1:0] randReport();
    logic [NR-1:0] v;
    v = {8'($urandom()), $urandom()};
    if (v == '0) v = 40'h1;
    return v;
  endfunction

  initial begin
    logic [NR-1:0] rep;
    smallRun = 1'b0; smallReports = '0; smallBus.out_ready = 1'b0;
    modelQ.delete(); modelTs = '0; modelOvf = 1'b0; modelDrops = 0;

    // Reset state
    applyStimulus(0, '0, 0, 0, 1);
    checkOutput("reset_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_data", 64'(bus.out_data), 64'd0);

    // Event in the third run cycle carries timestamp 2
    applyStimulus(1, '0, 0, 0, 0);
    applyStimulus(1, '0, 0, 0, 0);
    applyStimulus(1, 40'h1, 0, 0, 0);
    checkOutput("first_event_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("first_event_data", 64'(bus.out_data), {24'd2, 40'h1});
    // Holding while not ready keeps the head stable
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("hold_data", 64'(bus.out_data), {24'd2, 40'h1});
    applyStimulus(0, '0, 1, 0, 0);

    // Ten pushes into a depth-8 FIFO: two drops, then ordered drain
    applyStimulus(0, '0, 0, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1, randReport(), 0, 0, 0);
    checkOutput("burst_count", 64'(fifoCount), 64'd8);
    checkOutput("burst_overflow", 64'(overflow), 64'd1);
    checkOutput("burst_drops", 64'(dropCount), 64'd2);
    for (int i = 0; i < 8; i++) applyStimulus(0, '0, 1, 0, 0);
    checkOutput("drained_valid", 64'(bus.out_valid), 64'd0);

    // Push and pop together while full: no drop, tail takes the new event
    applyStimulus(0, '0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, randReport(), 0, 0, 0);
    applyStimulus(1, randReport(), 1, 0, 0);
    checkOutput("full_pushpop_count", 64'(fifoCount), 64'd8);
    checkOutput("full_pushpop_drops", 64'(dropCount), 64'd0);

    // A drop, then a drop coinciding with clear: clear wins
    applyStimulus(1, randReport(), 0, 0, 0);
    checkOutput("drop_sets_overflow", 64'(overflow), 64'd1);
    applyStimulus(1, randReport(), 0, 1, 0);
    checkOutput("clear_priority_ovf", 64'(overflow), 64'd0);
    checkOutput("clear_priority_drops", 64'(dropCount), 64'd0);
    for (int i = 0; i < 8; i++) applyStimulus(0, '0, 1, 0, 0);

    // run=0 ignores reports and holds the timestamp (next event shows it)
    for (int i = 0; i < 3; i++) applyStimulus(0, 40'hFF_FFFF_FFFF, 0, 0, 0);
    checkOutput("idle_no_event", 64'(fifoCount), 64'd0);
    applyStimulus(1, 40'h5, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rep = ($urandom_range(0, 9) < 3) ? '0 : randReport();
      applyStimulus($urandom_range(0, 3) != 0, rep, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
    end

    // Reset with five entries queued
    applyStimulus(0, '0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, randReport(), 0, 0, 0);
    checkOutput("queued_five", 64'(fifoCount), 64'd5);
    applyStimulus(1, randReport(), 1, 1, 1);
    checkOutput("reset_q_count", 64'(fifoCount), 64'd0);
    checkOutput("reset_q_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_q_data", 64'(bus.out_data), 64'd0);

    // Timestamp wrap on the narrow instance: 255 run cycles, then two events
    smallRun = 1'b1; smallReports = '0;
    for (int i = 0; i < 255; i++) applyStimulus(0, '0, 0, 0, 0);
    smallReports = 40'h1;
    applyStimulus(0, '0, 0, 0, 0);
    smallReports = 40'h2;
    applyStimulus(0, '0, 0, 0, 0);
    smallRun = 1'b0; smallReports = '0;
    checkOutput("wrap_count", 64'(smallCount), 64'd2);
    checkOutput("wrap_first", 64'(smallBus.out_data), 64'({8'hFF, 40'h1}));
    smallBus.out_ready = 1'b1;
    applyStimulus(0, '0, 0, 0, 0);
    smallBus.out_ready = 1'b0;
    checkOutput("wrap_second", 64'(smallBus.out_data), 64'({8'h00, 40'h2}));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/automata_report_collector.md
AUTOMATA_REPORT_COLLECTOR -- requirements
Module: automata_report_collector

Interface
REQ-001 SHALL have parameter NUM_REPORTS, default 40, giving the number of report wires from one automata stage (10 automata x 4 reports).
REQ-002 SHALL have parameter TS_WIDTH, default 24, giving the width of the run-cycle timestamp.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two, >=2), giving the number of report-event entries buffered.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port run, input, 1 bit: symbol-valid qualifier shared with the automata stage.
REQ-007 SHALL have port reports, input, NUM_REPORTS bits: report wires from the stage, in stage output order (ltl1, ltl8, ltl2, ltl3, ltl9, ltl6, ltl4, ltl5, ltl7, ltl0; each out_4, out_6, out_9, out_11), bit 0 first.
REQ-008 SHALL have port out_valid, output, 1 bit: head event available.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream reader accepts the head event.
REQ-010 SHALL have port out_data, output, TS_WIDTH+NUM_REPORTS bits: {timestamp, report vector}, with the timestamp in the MSBs.
REQ-011 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag set when any event has been dropped.
REQ-013 SHALL have port drop_count, output, 16 bits: number of dropped events, saturating.
REQ-014 SHALL have port clear_status, input, 1 bit: clears overflow and drop_count.

Function
REQ-015 SHALL keep a TS_WIDTH timestamp counter that increments by 1 on every clock with run=1, holds when run=0, and wraps from all-ones to 0.
REQ-016 SHALL capture an event in any cycle with run=1 and reports nonzero; the event is {current timestamp value before increment, reports}.
REQ-017 SHALL ignore reports in any cycle with run=0, and SHALL ignore all-zero report vectors.
REQ-018 SHALL write a captured event to the FIFO in the same clock edge; out_valid SHALL rise on the next cycle if the FIFO was empty (latency 1).
REQ-019 SHALL pop the head entry on any edge where out_valid=1 and out_ready=1.
REQ-020 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive out_data to all-zero whenever out_valid=0.
REQ-022 SHALL, on a push while full with no pop, drop the new event, set overflow, and increment drop_count, saturating at 0xFFFF; FIFO contents SHALL be unchanged.
REQ-023 SHALL, on a simultaneous push and pop while full, accept both, leaving fifo_count at FIFO_DEPTH with no drop.
REQ-024 SHALL, on a simultaneous push and pop while neither empty nor full, leave fifo_count unchanged.
REQ-025 SHALL never pop while empty; out_ready while empty SHALL have no effect.
REQ-026 SHALL wrap read and write pointers modulo FIFO_DEPTH and preserve event order.
REQ-027 SHALL, when clear_status=1 coincides with a drop, give clear priority: overflow=0 and drop_count=0 after the edge.
REQ-028 SHALL make fifo_count equal to the exact number of valid entries after every edge.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, set the timestamp to 0, empty the FIFO, and set out_valid=0, out_data=0, fifo_count=0, overflow=0 and drop_count=0.
REQ-030 SHALL give reset priority over run, push, pop and clear_status; reset SHALL discard any events in flight mid-operation.

Verification
REQ-031 SHALL cover: reset; run=1 for 3 cycles; reports=0x1 in the 3rd cycle -> the next cycle shows out_valid=1 and out_data={24'd2, 40'h1}.
REQ-032 SHALL cover: 10 consecutive report cycles with out_ready=0 and depth 8 -> fifo_count=8, overflow=1, drop_count=2; draining then yields the first 8 events in order.
REQ-033 SHALL cover: FIFO full, push and out_ready=1 in the same cycle -> no drop, fifo_count stays 8, new event at the tail.
REQ-034 SHALL cover: run=0 with reports=0xFF_FFFF_FFFF -> no event and the timestamp unchanged.
REQ-035 SHALL cover: timestamp preset near 0xFFFFFF via run cycles -> events carry 0xFFFFFF then 0x000000.
REQ-036 SHALL cover: reset asserted with 5 entries queued -> the next cycle shows fifo_count=0, out_valid=0, out_data=0.
